branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Fetch-side branch predictor. It consumes the branch-resolution updates the execute stage emits.
- Direct-mapped BTB: each entry holds a valid bit, tag, target address and a 2-bit saturating counter.
- Lookup on the fetch PC is combinational and yields predictedTaken plus a predicted target for the next-PC mux.
- Updates from execute are written on the clock edge.

Parameters:
- ENTRIES, 16, number of entries; power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES), index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_pc  input  32  PC currently being fetched.
- predictedTaken  output  1  lookup hit AND counter MSB = 1.
- predicted_target  output  32  target of the hit entry; 0 when predictedTaken = 0.
- update_btb  input  1  execute resolved a control-flow instruction; sampled each cycle.
- ex_pc  input  32  PC of the resolved instruction in execute.
- ex_taken  input  1  actual outcome: 1 = taken, JAL/JALR always 1.
- calc_jump_addr  input  32  resolved target address.
- pipeline_flush  input  1  when 1, the update is suppressed.
- hit  output  1  valid AND tag match on fetch_pc; for debug and counters.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- Per-entry state: valid (1), tag (30-IDX_W), target (32), ctr (2).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset, applied on the clk edge while rst = 1:
  - all valid = 0, all ctr = 01; tag and target are don't-care.
  - Outputs then read predictedTaken = 0, predicted_target = 0, hit = 0.
  - rst has priority over any simultaneous update.
- Lookup:
  - Purely combinational from fetch_pc and current array state, zero latency.
  - hit = valid[idx] && tag[idx] == fetch tag.
  - predictedTaken = hit && ctr[idx][1].
  - predicted_target = predictedTaken ? target[idx] : 0.
- An update is accepted when update_btb && !pipeline_flush && !rst. It takes effect at the next rising edge, one-cycle write latency. For entry e = ex_pc idx:
  - Hit (valid and tag match):
    - ex_taken = 1: ctr = sat-increment (11 stays 11); target = calc_jump_addr.
    - ex_taken = 0: ctr = sat-decrement (00 stays 00); target unchanged.
  - Miss, ex_taken = 1: allocate/replace. valid = 1, tag = ex tag, target = calc_jump_addr, ctr = 10.
  - Miss, ex_taken = 0: no state change; not-taken branches are never allocated.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state; there is no write-through bypass. The new state is visible from the following cycle.
- Aliasing: a different PC that maps to the same idx replaces the entry only on a taken miss. A not-taken alias leaves the entry intact.
- No stall input. Lookup is stateless, so a stalled fetch simply re-presents the same fetch_pc.
- Only one update port, so the block handles at most one update per cycle.
- All state resides in registers (no RAM macro), so the next cycle reflects any write exactly.

Test Plan:
1. Reset then lookup:
   - Assert rst for 2 cycles, then set fetch_pc = 0x0000_0040.
   - Required: hit = 0, predictedTaken = 0, predicted_target = 0.
2. Allocate on taken miss:
   - One update: ex_pc = 0x40, ex_taken = 1, calc_jump_addr = 0x100.
   - Next cycle, fetch_pc = 0x40 gives hit = 1, predictedTaken = 1 (ctr = 10), predicted_target = 0x100.
3. Counter hysteresis on entry 0x40 (ctr = 10):
   - Not-taken update: ctr = 01, predictedTaken = 0, hit = 1.
   - Taken update: ctr = 10, predictedTaken = 1.
   - Three taken updates: ctr saturates at 11.
   - One not-taken update: ctr = 10, still taken.
4. No allocate on not-taken miss, then alias replacement (ENTRIES = 16):
   - Not-taken update at ex_pc = 0x80: fetch 0x80 gives hit = 0.
   - Taken update at ex_pc = 0x440, same idx as 0x40, calc_jump_addr = 0x200.
   - Required: fetch 0x40 gives hit = 0; fetch 0x440 gives predictedTaken = 1, target = 0x200.
5. Flush and reset priority:
   - Taken update at ex_pc = 0x60 with pipeline_flush = 1: fetch 0x60 gives hit = 0.
   - Taken update at ex_pc = 0x60 with rst = 1 in the same cycle: all entries invalid afterwards.
6. Same-cycle read/write:
   - fetch_pc = 0x40 while a taken update to ex_pc = 0x40 with target 0x300 occurs (entry previously 0x100).
   - Required: that cycle predicted_target = 0x100; next cycle 0x300.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// Each entry holds a valid bit, a tag, a target address and a 2-bit
// saturating taken/not-taken counter. Lookup is combinational on the
// fetch PC; resolved branches from execute update the table on the clock.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        predictedTaken,
  output logic [31:0] predicted_target,
  input  logic        update_btb,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] calc_jump_addr,
  input  logic        pipeline_flush,
  output logic        hit
);

  localparam int TAG_W = 30 - IDX_W;

  // Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  // Saturating increment of the 2-bit direction counter.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b11;
      default: r = CTR_WEAK_NT;
    endcase
    return r;
  endfunction

  // Saturating decrement of the 2-bit direction counter.
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b00;
      2'b10:   r = 2'b01;
      2'b11:   r = 2'b10;
      default: r = CTR_WEAK_NT;
    endcase
    return r;
  endfunction

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx_s;
  logic [TAG_W-1:0] fetch_tag_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [TAG_W-1:0] ex_tag_s;
  logic             ex_hit_s;
  logic             update_accept_s;

  assign fetch_idx_s     = fetch_pc[IDX_W+1:2];
  assign fetch_tag_s     = fetch_pc[31:IDX_W+2];
  assign ex_idx_s        = ex_pc[IDX_W+1:2];
  assign ex_tag_s        = ex_pc[31:IDX_W+2];
  assign ex_hit_s        = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
  assign update_accept_s = update_btb && !pipeline_flush;

  // Zero-latency lookup; a target is only driven when the prediction is taken.
  always_comb begin
    hit              = 1'b0;
    predictedTaken   = 1'b0;
    predicted_target = 32'h0000_0000;
    if (valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s)) begin
      hit = 1'b1;
      if (ctr_r[fetch_idx_s][1]) begin
        predictedTaken   = 1'b1;
        predicted_target = target_r[fetch_idx_s];
      end else begin
        predictedTaken   = 1'b0;
        predicted_target = 32'h0000_0000;
      end
    end else begin
      hit              = 1'b0;
      predictedTaken   = 1'b0;
      predicted_target = 32'h0000_0000;
    end
  end

  // Table update: reset wins; otherwise train on hit, allocate on taken miss only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= CTR_WEAK_NT;
      end
    end else if (update_accept_s) begin
      if (ex_hit_s) begin
        if (ex_taken) begin
          ctr_r[ex_idx_s]    <= sat_inc(ctr_r[ex_idx_s]);
          target_r[ex_idx_s] <= calc_jump_addr;
        end else begin
          ctr_r[ex_idx_s]    <= sat_dec(ctr_r[ex_idx_s]);
        end
      end else if (ex_taken) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= calc_jump_addr;
        ctr_r[ex_idx_s]    <= CTR_WEAK_T;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (ENTRIES = 16).
// A table model indexed by arithmetic on the PC predicts the outputs every
// cycle; directed steps additionally pin hand-computed values.
module tb_branch_target_buffer;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predictedTaken;
  logic [31:0] predicted_target;
  logic        update_btb;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] calc_jump_addr;
  logic        pipeline_flush;
  logic        hit;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  branch_target_buffer #(.ENTRIES(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .predictedTaken   (predictedTaken),
    .predicted_target (predicted_target),
    .update_btb       (update_btb),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .calc_jump_addr   (calc_jump_addr),
    .pipeline_flush   (pipeline_flush),
    .hit              (hit)
  );

  always #5 clk = ~clk;

  // Model: per slot, remembered PC-tag (pc / 64), target and a 0..3 counter.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  int unsigned m_tgt   [N];
  int          m_ctr   [N];

  // Model update at the same edge where the DUT writes.
  always @(posedge clk) begin
    int i;
    bit h;
    i = int'((ex_pc / 4) % N);
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (update_btb && !pipeline_flush) begin
      h = m_valid[i] && (m_tag[i] == ex_pc / 64);
      if (h && ex_taken) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = calc_jump_addr;
      end else if (h) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (ex_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = ex_pc / 64;
        m_tgt[i]   = calc_jump_addr;
        m_ctr[i]   = 2;
      end
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int i;
    bit e_hit, e_pt;
    logic [31:0] e_tgt;
    if (chk_en) begin
      i     = int'((fetch_pc / 4) % N);
      e_hit = m_valid[i] && (m_tag[i] == fetch_pc / 64);
      e_pt  = e_hit && (m_ctr[i] >= 2);
      e_tgt = e_pt ? m_tgt[i] : 32'h0;
      n_cmp++;
      if (hit !== e_hit || predictedTaken !== e_pt || predicted_target !== e_tgt) begin
        n_bad++;
        $display("FAIL model t=%0t pc=%h got hit=%b pt=%b tgt=%h want hit=%b pt=%b tgt=%h",
                 $time, fetch_pc, hit, predictedTaken, predicted_target, e_hit, e_pt, e_tgt);
      end
    end
  end

  // Present one cycle of inputs, return mid-cycle (before the write edge).
  task automatic drive(input logic [31:0] fpc, input logic upd, input logic [31:0] epc,
                       input logic tk, input logic [31:0] tgt, input logic fl, input logic r);
    @(posedge clk);
    #1;
    fetch_pc       = fpc;
    update_btb     = upd;
    ex_pc          = epc;
    ex_taken       = tk;
    calc_jump_addr = tgt;
    pipeline_flush = fl;
    rst            = r;
    @(negedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] fpc);
    drive(fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] fpc, input logic [31:0] epc, input logic tk,
                     input logic [31:0] tgt);
    drive(fpc, 1'b1, epc, tk, tgt, 1'b0, 1'b0);
  endtask

  // Hand-computed expectation on the current outputs.
  task automatic lit(input string name, input logic e_hit, input logic e_pt,
                     input logic [31:0] e_tgt);
    n_cmp++;
    if (hit !== e_hit || predictedTaken !== e_pt || predicted_target !== e_tgt) begin
      n_bad++;
      $display("FAIL %s got hit=%b pt=%b tgt=%h want hit=%b pt=%b tgt=%h",
               name, hit, predictedTaken, predicted_target, e_hit, e_pt, e_tgt);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_pc = 32'h0; update_btb = 1'b0; ex_pc = 32'h0;
    ex_taken = 1'b0; calc_jump_addr = 32'h0; pipeline_flush = 1'b0;
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // 1. Reset then lookup
    look(32'h40);                         lit("reset_lookup", 1'b0, 1'b0, 32'h0);

    // 2. Allocate on taken miss
    upd(32'h40, 32'h40, 1'b1, 32'h100);   lit("alloc_pre", 1'b0, 1'b0, 32'h0);
    look(32'h40);                         lit("alloc_hit", 1'b1, 1'b1, 32'h100);

    // 3. Hysteresis: 10 -> 01 -> 10 -> 11 (sat) -> 10 -> 01 -> 10
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    look(32'h40);                         lit("ctr_weak_nt", 1'b1, 1'b0, 32'h0);
    upd(32'h40, 32'h40, 1'b1, 32'h100);
    look(32'h40);                         lit("ctr_weak_t", 1'b1, 1'b1, 32'h100);
    for (int k = 0; k < 3; k++) upd(32'h40, 32'h40, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    look(32'h40);                         lit("ctr_sat_then_nt", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    look(32'h40);                         lit("ctr_second_nt", 1'b1, 1'b0, 32'h0);
    upd(32'h40, 32'h40, 1'b1, 32'h100);

    // 4. No allocate on NT miss; alias replacement
    upd(32'h80, 32'h80, 1'b0, 32'h0);
    look(32'h80);                         lit("nt_no_alloc", 1'b0, 1'b0, 32'h0);
    upd(32'h40, 32'h440, 1'b1, 32'h200);
    look(32'h40);                         lit("alias_evicted", 1'b0, 1'b0, 32'h0);
    look(32'h440);                        lit("alias_new", 1'b1, 1'b1, 32'h200);

    // 5. Flush suppression and reset priority
    drive(32'h60, 1'b1, 32'h60, 1'b1, 32'h1234, 1'b1, 1'b0);
    look(32'h60);                         lit("flush_suppress", 1'b0, 1'b0, 32'h0);
    drive(32'h440, 1'b1, 32'h60, 1'b1, 32'h1234, 1'b0, 1'b1);
    lit("rst_cycle_pre", 1'b1, 1'b1, 32'h200);
    look(32'h440);                        lit("rst_cleared", 1'b0, 1'b0, 32'h0);
    look(32'h60);                         lit("rst_beats_update", 1'b0, 1'b0, 32'h0);

    // 6. Same-cycle read/write: old value this cycle, new value next
    upd(32'h40, 32'h40, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h300);   lit("rw_same_cycle", 1'b1, 1'b1, 32'h100);
    look(32'h40);                         lit("rw_next_cycle", 1'b1, 1'b1, 32'h300);
    look(32'h43);                         lit("low_bits_ignored", 1'b1, 1'b1, 32'h300);

    // Mixed traffic over a small PC range, checked against the model only
    for (int k = 0; k < 60; k++) begin
      drive({22'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00},
            1'($urandom_range(0, 1)),
            {22'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00},
            1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 7) == 0), 1'b0);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
